// File: rtl/axi_lite_mport_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_lite_mport_bridge_if
// Signal bundle between NPORT memory requesters, the multi-port AXI4-Lite
// bridge and the AXI4-Lite slave side.
//   Requester side : req_valid/mode/addr/wdata/wstrb in, req_ready and
//                    resp_valid/resp_data/resp_err out (bridge view).
//   AXI side       : AR, R, AW, W, B channels of a single AXI4-Lite master.
// Modports:
//   master : the bridge (drives AXI requests and requester responses)
//   slave  : the environment (requesters plus AXI slave/interconnect)
// Per-port fields are packed: port i occupies [i*W +: W].
// ---------------------------------------------------------------------------
interface axi_lite_mport_bridge_if #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  // requester side
  logic [NPORT-1:0]        req_valid;
  logic [NPORT-1:0]        req_mode;
  logic [NPORT*AW-1:0]     req_addr;
  logic [NPORT*DW-1:0]     req_wdata;
  logic [NPORT*DW/8-1:0]   req_wstrb;
  logic [NPORT-1:0]        req_ready;
  logic [NPORT-1:0]        resp_valid;
  logic [DW-1:0]           resp_data;
  logic                    resp_err;
  // AXI4-Lite AR / R
  logic [AW-1:0]           axi_araddr;
  logic [2:0]              axi_arprot;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [DW-1:0]           axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rvalid;
  logic                    axi_rready;
  // AXI4-Lite AW / W / B
  logic [AW-1:0]           axi_awaddr;
  logic [2:0]              axi_awprot;
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [DW-1:0]           axi_wdata;
  logic [DW/8-1:0]         axi_wstrb;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [1:0]              axi_bresp;
  logic                    axi_bvalid;
  logic                    axi_bready;

  modport master (
    input  req_valid, req_mode, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_data, resp_err,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready,
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport slave (
    output req_valid, req_mode, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready,
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/axi_lite_mport_bridge.sv
// ---------------------------------------------------------------------------
// axi_lite_mport_bridge
// Round-robin arbiter feeding NPORT memory requesters into one AXI4-Lite
// master port. One transaction is in flight at a time; AW and W are issued
// together and may be accepted in either order.
// Ports:
//   clk  - clock
//   rstn - synchronous, active-low reset (abandons any open transaction)
//   bus  - axi_lite_mport_bridge_if.master: requester handshake
//          (req_*/resp_*) and the AR/R/AW/W/B channels
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module axi_lite_mport_bridge #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_lite_mport_bridge_if.master  bus
);
  localparam int SW = DW / 8;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t           state_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    gnt_q;
  logic [NPORT-1:0] req_ready_q;
  logic [NPORT-1:0] resp_valid_q;
  logic [DW-1:0]    resp_data_q;
  logic             resp_err_q;
  logic [AW-1:0]    araddr_q;
  logic             arvalid_q;
  logic             rready_q;
  logic [AW-1:0]    awaddr_q;
  logic             awvalid_q;
  logic [DW-1:0]    wdata_q;
  logic [SW-1:0]    wstrb_q;
  logic             wvalid_q;
  logic             bready_q;

  // Unpacked per-port views of the packed request fields.
  logic [AW-1:0] port_addr  [NPORT];
  logic [DW-1:0] port_wdata [NPORT];
  logic [SW-1:0] port_wstrb [NPORT];

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      assign port_addr[gi]  = bus.req_addr[gi*AW +: AW];
      assign port_wdata[gi] = bus.req_wdata[gi*DW +: DW];
      assign port_wstrb[gi] = bus.req_wstrb[gi*SW +: SW];
    end
  endgenerate

  // Round-robin pick: first requester at or after rr_ptr, cyclically upward.
  // Offsets are scanned from the far end so the smallest offset wins.
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [PW-1:0] next_ptr;
  int            cand;
  logic [PW-1:0] cand_pw;

  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = 0;
    cand_pw  = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      cand    = (int'(rr_ptr_q) + k) % NPORT;
      cand_pw = PW'(cand);
      if (bus.req_valid[cand_pw]) begin
        pick_idx = cand_pw;
        pick_vld = 1'b1;
      end
    end
  end

  assign next_ptr = (pick_idx == PW'(NPORT - 1)) ? '0 : pick_idx + 1'b1;

  // W or AW counts as done if already accepted or accepted this cycle.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || bus.axi_awready;
  assign w_done  = !wvalid_q  || bus.axi_wready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          // The cycle carrying resp_valid never grants, so a requester sees
          // its completion before it can be granted again.
          if (pick_vld && !(|resp_valid_q)) begin
            gnt_q                 <= pick_idx;
            req_ready_q[pick_idx] <= 1'b1;
            rr_ptr_q              <= next_ptr;
            if (bus.req_mode[pick_idx]) begin
              awaddr_q  <= port_addr[pick_idx];
              wdata_q   <= port_wdata[pick_idx];
              wstrb_q   <= port_wstrb[pick_idx];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= port_addr[pick_idx];
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arvalid_q && bus.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready_q && bus.axi_rvalid) begin
            rready_q            <= 1'b0;
            resp_data_q         <= bus.axi_rdata;
            resp_err_q          <= bus.axi_rresp[1];
            resp_valid_q[gnt_q] <= 1'b1;
            state_q             <= IDLE;
          end
        end
        WR_REQ: begin
          if (awvalid_q && bus.axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready_q && bus.axi_bvalid) begin
            bready_q            <= 1'b0;
            resp_err_q          <= bus.axi_bresp[1];
            resp_valid_q[gnt_q] <= 1'b1;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the SLVERR/DECERR bit of the response codes matters here.
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{bus.axi_rresp[0], bus.axi_bresp[0]};

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_rready  = rready_q;
  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awprot  = 3'b000;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_mport_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mport_bridge
// Directed and randomized checks of axi_lite_mport_bridge (NPORT=3) against
// a small AXI4-Lite slave with programmable wait states and a reference
// model that tracks the expected grant, response port, data and error.
// ---------------------------------------------------------------------------
module tb_axi_lite_mport_bridge;
  localparam int NPORT = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_mport_bridge_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) bus();

  axi_lite_mport_bridge #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ AXI slave
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [DW-1:0] rdata_cfg = '0;
  logic [1:0]    rresp_cfg = '0;
  logic [1:0]    bresp_cfg = '0;

  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, cyc;
  bit r_pend, b_pend, aw_got, w_got;
  int aw_hs_cyc, w_hs_cyc;
  logic [AW-1:0] cap_araddr, cap_awaddr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_wstrb;

  assign bus.axi_arready = bus.axi_arvalid && (ar_cnt >= ar_wait);
  assign bus.axi_rvalid  = r_pend && (r_cnt >= r_wait);
  assign bus.axi_rdata   = rdata_cfg;
  assign bus.axi_rresp   = rresp_cfg;
  assign bus.axi_awready = bus.axi_awvalid && (aw_cnt >= aw_wait);
  assign bus.axi_wready  = bus.axi_wvalid && (w_cnt >= w_wait);
  assign bus.axi_bvalid  = b_pend && (b_cnt >= b_wait);
  assign bus.axi_bresp   = bresp_cfg;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (bus.axi_arvalid && !bus.axi_arready) ar_cnt <= ar_cnt + 1;
      if (bus.axi_arvalid && bus.axi_arready) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; cap_araddr <= bus.axi_araddr;
      end
      if (r_pend && !bus.axi_rvalid) r_cnt <= r_cnt + 1;
      if (bus.axi_rvalid && bus.axi_rready) r_pend <= 1'b0;
      if (bus.axi_awvalid && !bus.axi_awready) aw_cnt <= aw_cnt + 1;
      if (bus.axi_awvalid && bus.axi_awready) begin
        aw_cnt <= 0; cap_awaddr <= bus.axi_awaddr; aw_hs_cyc <= cyc;
      end
      if (bus.axi_wvalid && !bus.axi_wready) w_cnt <= w_cnt + 1;
      if (bus.axi_wvalid && bus.axi_wready) begin
        w_cnt <= 0; cap_wdata <= bus.axi_wdata; cap_wstrb <= bus.axi_wstrb; w_hs_cyc <= cyc;
      end
      if ((aw_got || (bus.axi_awvalid && bus.axi_awready)) &&
          (w_got  || (bus.axi_wvalid  && bus.axi_wready))) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (bus.axi_awvalid && bus.axi_awready) aw_got <= 1'b1;
        if (bus.axi_wvalid && bus.axi_wready)   w_got  <= 1'b1;
      end
      if (b_pend && !bus.axi_bvalid) b_cnt <= b_cnt + 1;
      if (bus.axi_bvalid && bus.axi_bready) b_pend <= 1'b0;
    end
  end

  // ------------------------------------------------------------ monitors
  int viol = 0, ar_stall = 0, r_stall = 0, resp_pulses = 0, onehot_bad = 0;
  bit ar_hold, aw_hold, w_hold;
  logic [AW-1:0] ar_addr_prev, aw_addr_prev;
  logic [DW-1:0] w_data_prev;

  always @(posedge clk) begin
    if (!rstn) begin
      ar_hold <= 1'b0; aw_hold <= 1'b0; w_hold <= 1'b0;
    end else begin
      // a valid not yet accepted must stay up with unchanged payload
      if (ar_hold && (!bus.axi_arvalid || bus.axi_araddr !== ar_addr_prev)) viol <= viol + 1;
      if (aw_hold && (!bus.axi_awvalid || bus.axi_awaddr !== aw_addr_prev)) viol <= viol + 1;
      if (w_hold && (!bus.axi_wvalid || bus.axi_wdata !== w_data_prev)) viol <= viol + 1;
      if (bus.axi_bready && (bus.axi_awvalid || bus.axi_wvalid)) viol <= viol + 1;
      if (bus.axi_arprot !== 3'b000 || bus.axi_awprot !== 3'b000) viol <= viol + 1;
      ar_hold      <= bus.axi_arvalid && !bus.axi_arready;
      aw_hold      <= bus.axi_awvalid && !bus.axi_awready;
      w_hold       <= bus.axi_wvalid && !bus.axi_wready;
      ar_addr_prev <= bus.axi_araddr;
      aw_addr_prev <= bus.axi_awaddr;
      w_data_prev  <= bus.axi_wdata;
      if (bus.axi_arvalid && !bus.axi_arready) ar_stall <= ar_stall + 1;
      if (bus.axi_rready && !bus.axi_rvalid)   r_stall  <= r_stall + 1;
    end
  end

  always @(negedge clk) begin
    if (|bus.resp_valid) resp_pulses <= resp_pulses + 1;
    if ((|bus.req_ready && !$onehot(bus.req_ready)) ||
        (|bus.resp_valid && !$onehot(bus.resp_valid))) onehot_bad <= onehot_bad + 1;
  end

  // ------------------------------------------------------------ model
  logic [DW-1:0] model_rdata = '0;  // resp_data holds the last read value

  task automatic set_req(input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.req_valid[p]            = 1'b1;
    bus.req_mode[p]             = wr;
    bus.req_addr[p*AW +: AW]    = a;
    bus.req_wdata[p*DW +: DW]   = d;
    bus.req_wstrb[p*SW +: SW]   = s;
  endtask

  task automatic wait_grant(output logic [NPORT-1:0] g);
    int n = 0;
    @(negedge clk);
    while (!(|bus.req_ready) && n < 300) begin @(negedge clk); n++; end
    g = bus.req_ready;
  endtask

  task automatic wait_resp(output logic [NPORT-1:0] r);
    int n = 0;
    while (!(|bus.resp_valid) && n < 300) begin @(negedge clk); n++; end
    r = bus.resp_valid;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_rdata = '0;
    @(negedge clk);
  endtask

  // One complete transaction from an otherwise idle requester set.
  task automatic run_txn(input string tag, input int p, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [DW-1:0] rd,
                         input logic [1:0] rsp);
    logic [NPORT-1:0] g, r;
    int pulses0;
    rdata_cfg = rd; rresp_cfg = rsp; bresp_cfg = rsp;
    pulses0 = resp_pulses;
    set_req(p, wr, a, d, s);
    wait_grant(g);
    chk({tag, "_grant"}, 64'(g), 64'(1) << p);
    // fields after the grant must be ignored
    bus.req_valid[p] = 1'b0;
    bus.req_mode[p]  = ~wr;
    bus.req_addr[p*AW +: AW]  = $urandom;
    bus.req_wdata[p*DW +: DW] = $urandom;
    bus.req_wstrb[p*SW +: SW] = SW'($urandom);
    wait_resp(r);
    if (!wr) model_rdata = rd;
    chk({tag, "_resp_port"}, 64'(r), 64'(1) << p);
    chk({tag, "_resp_data"}, 64'(bus.resp_data), 64'(model_rdata));
    chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'(rsp[1]));
    if (wr) begin
      chk({tag, "_awaddr"}, 64'(cap_awaddr), 64'(a));
      chk({tag, "_wdata"},  64'(cap_wdata),  64'(d));
      chk({tag, "_wstrb"},  64'(cap_wstrb),  64'(s));
    end else begin
      chk({tag, "_araddr"}, 64'(cap_araddr), 64'(a));
    end
    @(negedge clk);
    chk({tag, "_one_pulse"}, 64'(resp_pulses - pulses0), 64'd1);
    $display("txn %s port=%0d %s addr=%h data=%h err=%0d", tag, p, wr ? "WR" : "RD",
             a, bus.resp_data, bus.resp_err);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [NPORT-1:0] g, r;
    int s0, s1, pulses0;

    bus.req_valid = '0; bus.req_mode = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", 64'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.axi_arvalid,
                            bus.axi_rready, bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready}), 64'd0);
    chk("rst_data", 64'(bus.resp_data), 64'd0);
    chk("rst_addr", 64'({bus.axi_araddr, bus.axi_awaddr}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // zero-wait read, port 0, cycle-exact
    rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
    set_req(0, 1'b0, 32'h8000_0010, '0, '0);
    @(negedge clk);
    chk("rd0_t1_req_ready", 64'(bus.req_ready), 64'b001);
    chk("rd0_t1_arvalid", 64'(bus.axi_arvalid), 64'd1);
    chk("rd0_t1_araddr", 64'(bus.axi_araddr), 64'h8000_0010);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rd0_t2_rready", 64'(bus.axi_rready), 64'd1);
    @(negedge clk);
    model_rdata = 32'hDEAD_BEEF;
    chk("rd0_t3_resp_valid", 64'(bus.resp_valid), 64'b001);
    chk("rd0_t3_resp_data", 64'(bus.resp_data), 64'(model_rdata));
    chk("rd0_t3_resp_err", 64'(bus.resp_err), 64'd0);
    $display("txn rd0 port=0 RD addr=80000010 data=%h", bus.resp_data);
    @(negedge clk);

    // zero-wait write, port 2, cycle-exact
    bresp_cfg = 2'b00;
    set_req(2, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("wr2_t1_aw_w_valid", 64'({bus.axi_awvalid, bus.axi_wvalid}), 64'b11);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("wr2_t2_bready", 64'(bus.axi_bready), 64'd1);
    @(negedge clk);
    chk("wr2_t3_resp_valid", 64'(bus.resp_valid), 64'b100);
    chk("wr2_t3_data_kept", 64'(bus.resp_data), 64'(model_rdata));
    $display("txn wr2 port=2 WR addr=00000040 err=%0d", bus.resp_err);
    @(negedge clk);

    // split write handshakes: W accepted 2 cycles before AW
    aw_wait = 2; w_wait = 0;
    run_txn("wr_split", 1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, '0, 2'b00);
    chk("wr_split_order", 64'(aw_hs_cyc - w_hs_cyc), 64'd2);
    aw_wait = 0;

    // error responses: write then read
    run_txn("err_wr", 0, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'hF, '0, 2'b10);
    run_txn("err_rd", 2, 1'b0, 32'h0000_3000, '0, '0, 32'h0BAD_0BAD, 2'b11);

    // backpressure on AR then on R
    ar_wait = 5; r_wait = 3;
    s0 = ar_stall; s1 = r_stall;
    run_txn("bp_rd", 1, 1'b0, 32'h0000_4444, '0, '0, 32'h7777_1111, 2'b00);
    chk("bp_ar_stall", 64'(ar_stall - s0), 64'd5);
    chk("bp_r_stall", 64'(r_stall - s1), 64'd3);
    ar_wait = 0; r_wait = 0;

    // randomized single-requester traffic with random wait states
    for (int i = 0; i < 24; i++) begin
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
      b_wait  = $urandom_range(0, 3);
      run_txn("rand", $urandom_range(0, NPORT - 1), 1'($urandom_range(0, 1)),
              $urandom, $urandom, SW'($urandom), $urandom, 2'($urandom));
    end
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;

    // round robin with all ports requesting continuously, from reset
    apply_reset();
    for (int p = 0; p < NPORT; p++) set_req(p, 1'b0, 32'h100 * (p + 1), '0, '0);
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      chk("rr_grant", 64'(g), 64'(1) << (k % NPORT));
      if (k == 5) bus.req_valid = '0;
      rdata_cfg = $urandom; rresp_cfg = 2'b00;
      wait_resp(r);
      chk("rr_resp_port", 64'(r), 64'(g));
      chk("rr_resp_data", 64'(bus.resp_data), 64'(rdata_cfg));
      $display("txn rr k=%0d grant=%b data=%h", k, g, bus.resp_data);
    end
    model_rdata = rdata_cfg;
    @(negedge clk);

    // reset in the middle of a write
    aw_wait = 10; w_wait = 10;
    set_req(1, 1'b1, 32'h0000_5000, 32'h9999_0000, 4'hF);
    wait_grant(g);
    chk("rstmid_grant", 64'(g), 64'b010);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_in_wr_req", 64'({bus.axi_awvalid, bus.axi_wvalid}), 64'b11);
    pulses0 = resp_pulses;
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_valids", 64'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
                              bus.axi_wvalid, bus.axi_bready, bus.req_ready, bus.resp_valid}), 64'd0);
    chk("rstmid_resp", 64'({bus.resp_data, bus.resp_err}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_rdata = '0;
    aw_wait = 0; w_wait = 0;
    repeat (5) @(negedge clk);
    chk("rstmid_no_resp", 64'(resp_pulses - pulses0), 64'd0);
    rdata_cfg = 32'h0123_4567; rresp_cfg = 2'b00;
    set_req(0, 1'b0, 32'h0000_6000, '0, '0);
    set_req(2, 1'b0, 32'h0000_7000, '0, '0);
    wait_grant(g);
    chk("rstmid_fresh_grant", 64'(g), 64'b001);
    bus.req_valid = '0;
    wait_resp(r);
    chk("rstmid_fresh_resp", 64'(r), 64'b001);
    chk("rstmid_fresh_data", 64'(bus.resp_data), 64'h0123_4567);
    $display("txn rstmid port=0 RD addr=00006000 data=%h", bus.resp_data);
    repeat (2) @(negedge clk);

    chk("protocol_rules", 64'(viol), 64'd0);
    chk("onehot_pulses", 64'(onehot_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
